reset_sequencer: RTL and testbench

- Parametrised multi-channel reset sequencer for the housekeeping domain.
- Runs on one clock.
- Applies a global boot delay, then releases NUM_CH active-low resets in ascending channel order, with a minimum assert length per channel and a fixed gap between releases.
- In RUN it watches per-channel maskable reset requests and re-sequences affected channels, optionally cascading a reset to all higher channels (dependency chain).
- Its outputs feed downstream per-domain reset synchronisers.

---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/reset_sequencer_chan.sv | 59 +++++
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Purpose: shared state encoding and width helper for the reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Number of bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/reset_sequencer_chan.sv
// Purpose: one reset channel: request synchroniser, mask, minimum-length counter, nrst register.
// Latency: request falling edge to nrst_o low in SYNC_STAGES+1 edges; release one edge after release_i.
// Backpressure: none; assertion always wins over release and ignores clk_en_i.
module reset_sequencer_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_LEN     = 4
) (
  input  logic clk,
  input  logic async_rst_i,
  input  logic clk_en_i,
  input  logic nrst_req_i,
  input  logic mask_i,
  input  logic assert_i,
  input  logic release_i,
  output logic eff_req_o,
  output logic len_zero_o,
  output logic nrst_o
);
  import rst_seq_pkg::*;

  localparam int LEN_W = clog2_min1(RST_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(RST_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [LEN_W-1:0]       len_cnt_q;
  logic                   nrst_q;

  // Request synchroniser; clears to "request asserted" so channels start held.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], nrst_req_i};
    end
  end

  assign eff_req_o  = ~sync_q[SYNC_STAGES-1] & ~mask_i;
  assign len_zero_o = (len_cnt_q == '0);
  assign nrst_o     = nrst_q;

  // Output register and minimum-low counter; an assert on the same edge as a release keeps the channel low.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      nrst_q    <= 1'b0;
      len_cnt_q <= LEN_INIT;
    end else if (assert_i) begin
      nrst_q    <= 1'b0;
      len_cnt_q <= LEN_INIT;
    end else begin
      if (release_i) begin
        nrst_q <= 1'b1;
      end
      if (clk_en_i && !nrst_q && (len_cnt_q != '0)) begin
        len_cnt_q <= len_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: boot delay then ordered release of NUM_CH active-low resets; re-sequences channels on request.
// Latency: first release BOOT_DLY+2 enabled edges after reset, then one release per GAP+1 enabled edges.
// Backpressure: none; clk_en_i stalls counters and releases but never delays assertion.
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int BOOT_DLY    = 255,
  parameter int RST_LEN     = 4,
  parameter int GAP         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              async_rst_i,
  input  logic              clk_en_i,
  input  logic [NUM_CH-1:0] nrst_req_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic              chain_i,
  output logic [NUM_CH-1:0] nrst_o,
  output logic              seq_done_o,
  output logic [1:0]        state_o
);
  import rst_seq_pkg::*;

  localparam int BOOT_W = clog2_min1(BOOT_DLY + 1);
  localparam int GAP_W  = clog2_min1(GAP + 1);
  localparam int IDX_W  = clog2_min1(NUM_CH);
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_DLY);
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP);

  state_e             state_q;
  logic [BOOT_W-1:0]  boot_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               seq_done_q;

  logic [NUM_CH-1:0]  eff_req;
  logic [NUM_CH-1:0]  len_zero;
  logic [NUM_CH-1:0]  nrst;
  logic [NUM_CH-1:0]  asrt;
  logic [NUM_CH-1:0]  rel;
  logic               any_req;
  logic               any_below;
  logic [IDX_W-1:0]   low_idx_d;
  logic [IDX_W-1:0]   nxt_idx_d;
  logic               nxt_found_d;
  logic               rel_fire;
  logic               step_ok;

  // Assertion vector with optional cascade to higher channels, plus the lowest requesting channel.
  always_comb begin
    asrt      = '0;
    low_idx_d = '0;
    any_below = 1'b0;
    any_req   = |eff_req;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eff_req[k]) low_idx_d = IDX_W'(k);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      asrt[k]   = eff_req[k] | (chain_i & any_below);
      any_below = any_below | eff_req[k];
    end
  end

  // Release decision for the channel under idx and the next channel still (or about to be) held low.
  always_comb begin
    rel         = '0;
    nxt_idx_d   = '0;
    nxt_found_d = 1'b0;
    rel_fire    = (state_q == ST_RELEASE) && clk_en_i && (gap_cnt_q == '0) &&
                  !nrst[idx_q] && !asrt[idx_q] && len_zero[idx_q];
    step_ok     = (state_q == ST_RELEASE) && clk_en_i && (gap_cnt_q == '0) &&
                  (nrst[idx_q] || rel_fire);
    for (int k = 0; k < NUM_CH; k++) begin
      rel[k] = rel_fire && (idx_q == IDX_W'(k));
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if ((k > int'(idx_q)) && (!nrst[k] || asrt[k])) begin
        nxt_idx_d   = IDX_W'(k);
        nxt_found_d = 1'b1;
      end
    end
  end

  // Sequencing FSM: boot delay, ordered release with gap, run-time re-sequencing.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      seq_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (clk_en_i) begin
            if (boot_cnt_q == '0) begin
              state_q <= ST_RELEASE;
              idx_q   <= '0;
            end else begin
              boot_cnt_q <= boot_cnt_q - 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (clk_en_i && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end else if (step_ok) begin
            if (nxt_found_d) begin
              idx_q <= nxt_idx_d;
              if (rel_fire) gap_cnt_q <= GAP_INIT;
            end else begin
              state_q    <= ST_RUN;
              seq_done_q <= 1'b1;
            end
          end
          // A new request at or below idx pulls the pointer back and cancels any finish.
          if (any_req && (low_idx_d <= idx_q)) begin
            idx_q      <= low_idx_d;
            state_q    <= ST_RELEASE;
            seq_done_q <= 1'b0;
            if (low_idx_d < idx_q) gap_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (any_req) begin
            state_q    <= ST_RELEASE;
            seq_done_q <= 1'b0;
            idx_q      <= low_idx_d;
            gap_cnt_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    reset_sequencer_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_LEN    (RST_LEN)
    ) u_chan (
      .clk        (clk),
      .async_rst_i(async_rst_i),
      .clk_en_i   (clk_en_i),
      .nrst_req_i (nrst_req_i[k]),
      .mask_i     (mask_i[k]),
      .assert_i   (asrt[k]),
      .release_i  (rel[k]),
      .eff_req_o  (eff_req[k]),
      .len_zero_o (len_zero[k]),
      .nrst_o     (nrst[k])
    );
  end

  assign nrst_o     = nrst;
  assign seq_done_o = seq_done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: self-checking bench for reset_sequencer with NUM_CH=3, BOOT_DLY=8, RST_LEN=4, GAP=2.
// Latency: expectations are keyed to edge numbers counted after async_rst_i deasserts.
// Backpressure: n/a.
module tb_reset_sequencer;
  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           async_rst_i;
  logic           clk_en_i;
  logic [NCH-1:0] nrst_req_i;
  logic [NCH-1:0] mask_i;
  logic           chain_i;
  logic [NCH-1:0] nrst_o;
  logic           seq_done_o;
  logic [1:0]     state_o;

  typedef struct {
    int         ed;
    logic [2:0] nrst;
    logic       done;
    logic [1:0] st;
    string      nm;
  } exp_t;

  exp_t boot_tbl[7];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ec     = 0;
  int   base;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(NCH), .BOOT_DLY(8), .RST_LEN(4), .GAP(2), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .async_rst_i(async_rst_i),
    .clk_en_i   (clk_en_i),
    .nrst_req_i (nrst_req_i),
    .mask_i     (mask_i),
    .chain_i    (chain_i),
    .nrst_o     (nrst_o),
    .seq_done_o (seq_done_o),
    .state_o    (state_o)
  );

  task automatic check_now(input string nm, input logic [2:0] n, input logic d, input logic [1:0] s);
    checks++;
    if (nrst_o !== n || seq_done_o !== d || state_o !== s) begin
      errors++;
      $display("FAIL %s @edge %0d: got nrst_o=%b seq_done_o=%b state_o=%0d, want nrst_o=%b seq_done_o=%b state_o=%0d",
               nm, ec, nrst_o, seq_done_o, state_o, n, d, s);
    end
  endtask

  task automatic expect_at(input int ed, input logic [2:0] n, input logic d, input logic [1:0] s, input string nm);
    exp_t e;
    e.ed = ed; e.nrst = n; e.done = d; e.st = s; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Advance n edges; sample 1ns after each edge and retire any expectation due by now.
  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      ec++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].ed <= ec) begin
        e = exp_q.pop_front();
        check_now(e.nm, e.nrst, e.done, e.st);
      end
    end
  endtask

  task automatic push_boot(input int shift, input int upto);
    foreach (boot_tbl[i]) begin
      if (boot_tbl[i].ed <= upto)
        expect_at(boot_tbl[i].ed + shift, boot_tbl[i].nrst, boot_tbl[i].done, boot_tbl[i].st, boot_tbl[i].nm);
    end
  endtask

  task automatic do_reset();
    #2 async_rst_i = 1'b1;
    #1 check_now("reset_async", 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    async_rst_i = 1'b0;
    ec = 0;
  endtask

  task automatic pulse_req(input int ch);
    nrst_req_i[ch] = 1'b0;
    tick(1);
    nrst_req_i[ch] = 1'b1;
  endtask

  initial begin
    boot_tbl[0] = '{8,  3'b000, 1'b0, 2'd0, "boot_hold"};
    boot_tbl[1] = '{9,  3'b000, 1'b0, 2'd1, "boot_to_release"};
    boot_tbl[2] = '{10, 3'b001, 1'b0, 2'd1, "rel_ch0"};
    boot_tbl[3] = '{12, 3'b001, 1'b0, 2'd1, "gap_ch1"};
    boot_tbl[4] = '{13, 3'b011, 1'b0, 2'd1, "rel_ch1"};
    boot_tbl[5] = '{15, 3'b011, 1'b0, 2'd1, "gap_ch2"};
    boot_tbl[6] = '{16, 3'b111, 1'b1, 2'd2, "rel_ch2_run"};

    async_rst_i = 1'b1;
    clk_en_i    = 1'b1;
    nrst_req_i  = '1;
    mask_i      = '0;
    chain_i     = 1'b0;

    // Power-up.
    repeat (2) @(posedge clk);
    #1 check_now("reset_state", 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    async_rst_i = 1'b0;
    ec = 0;
    push_boot(0, 99);
    tick(16);

    // Single-channel re-request, no chain.
    base = ec;
    expect_at(base + 2, 3'b111, 1'b1, 2'd2, "ch1_pre_drop");
    expect_at(base + 3, 3'b101, 1'b0, 2'd1, "ch1_drop");
    expect_at(base + 7, 3'b101, 1'b0, 2'd1, "ch1_min_len");
    expect_at(base + 8, 3'b111, 1'b1, 2'd2, "ch1_rerelease");
    pulse_req(1);
    tick(9);

    // Same request with chain: ch1 and ch2 drop together, released GAP+1 apart.
    chain_i = 1'b1;
    base = ec;
    expect_at(base + 2,  3'b111, 1'b1, 2'd2, "chain_pre_drop");
    expect_at(base + 3,  3'b001, 1'b0, 2'd1, "chain_drop");
    expect_at(base + 7,  3'b001, 1'b0, 2'd1, "chain_min_len");
    expect_at(base + 8,  3'b011, 1'b0, 2'd1, "chain_rel_ch1");
    expect_at(base + 10, 3'b011, 1'b0, 2'd1, "chain_gap_ch2");
    expect_at(base + 11, 3'b111, 1'b1, 2'd2, "chain_rel_ch2");
    pulse_req(1);
    tick(11);

    // Masked request held low has no effect.
    mask_i[0] = 1'b1;
    nrst_req_i[0] = 1'b0;
    base = ec;
    expect_at(base + 3,  3'b111, 1'b1, 2'd2, "mask_hold_a");
    expect_at(base + 10, 3'b111, 1'b1, 2'd2, "mask_hold_b");
    tick(10);

    // Unmask with chain off: only ch0 re-sequences.
    chain_i = 1'b0;
    mask_i[0] = 1'b0;
    base = ec;
    expect_at(base + 1, 3'b110, 1'b0, 2'd1, "unmask_drop");
    expect_at(base + 5, 3'b110, 1'b0, 2'd1, "unmask_held");
    tick(5);
    nrst_req_i[0] = 1'b1;
    base = ec;
    expect_at(base + 6, 3'b110, 1'b0, 2'd1, "unmask_len");
    expect_at(base + 7, 3'b111, 1'b1, 2'd2, "unmask_rel");
    tick(8);

    // Held request on ch0 with chain: everything re-sequences.
    chain_i = 1'b1;
    nrst_req_i[0] = 1'b0;
    base = ec;
    expect_at(base + 2, 3'b111, 1'b1, 2'd2, "chain0_pre");
    expect_at(base + 3, 3'b000, 1'b0, 2'd1, "chain0_drop");
    expect_at(base + 6, 3'b000, 1'b0, 2'd1, "chain0_held");
    tick(6);
    nrst_req_i[0] = 1'b1;
    base = ec;
    expect_at(base + 6,  3'b000, 1'b0, 2'd1, "chain0_len");
    expect_at(base + 7,  3'b001, 1'b0, 2'd1, "chain0_rel0");
    expect_at(base + 10, 3'b011, 1'b0, 2'd1, "chain0_rel1");
    expect_at(base + 13, 3'b111, 1'b1, 2'd2, "chain0_rel2");
    tick(14);
    chain_i = 1'b0;

    // Stalled clock enable in RUN: assertion still happens, release waits for enable.
    clk_en_i = 1'b0;
    base = ec;
    expect_at(base + 3,  3'b101, 1'b0, 2'd1, "stall_drop");
    expect_at(base + 10, 3'b101, 1'b0, 2'd1, "stall_frozen");
    pulse_req(1);
    tick(9);
    clk_en_i = 1'b1;
    base = ec;
    expect_at(base + 4, 3'b101, 1'b0, 2'd1, "stall_len");
    expect_at(base + 5, 3'b111, 1'b1, 2'd2, "stall_rel");
    tick(5);

    // Boot with enable low on edges 5..20 and a request inside the stall.
    do_reset();
    expect_at(4,  3'b000, 1'b0, 2'd0, "bstall_early");
    expect_at(13, 3'b000, 1'b0, 2'd0, "bstall_req");
    expect_at(20, 3'b000, 1'b0, 2'd0, "bstall_end");
    push_boot(16, 99);
    tick(4);
    clk_en_i = 1'b0;
    tick(6);
    pulse_req(2);
    tick(9);
    clk_en_i = 1'b1;
    tick(12);

    // Asynchronous reset mid-sequence, then a full replay.
    do_reset();
    push_boot(0, 12);
    tick(12);
    do_reset();
    push_boot(0, 99);
    tick(16);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
